// File: rtl/dpram_pkg.sv
// ----------------------------------------------------------------------------
// dpram_pkg
//  Shared types and constants for the parametrised true dual-port RAM.
//  - dpram_state_t : clear-sequencer FSM states
//  - RDW_*         : values for the RDW_MODE parameter
// ----------------------------------------------------------------------------
package dpram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } dpram_state_t;

    // Same-port read-during-write behaviour
    localparam int RDW_READ_FIRST  = 0;  // read returns the word before the write
    localparam int RDW_WRITE_FIRST = 1;  // read returns the data being written

endpackage : dpram_pkg

// File: rtl/dpram_clear_seq.sv
// ----------------------------------------------------------------------------
// dpram_clear_seq
//  Clear sequencer. After reset, or on a clr request while READY, it walks an
//  address counter through every word (one per cycle) so the top level can
//  overwrite the array with the initial value.
// Ports
//  clk        in   clock
//  rst        in   asynchronous reset, active-high (restarts the sequence at 0)
//  clr        in   request to re-run the clear sequence (ignored during INIT)
//  init_busy  out  sequence running (registered)
//  init_we    out  write strobe for the clear write
//  init_addr  out  address of the clear write
// ----------------------------------------------------------------------------
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              init_busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);

    dpram_state_t      r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Last word is being written this cycle; the counter
                    // wraps back to 0 naturally.
                    if (&r_cnt) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (clr) begin
                        r_state <= ST_INIT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign init_busy = r_busy;
    assign init_we   = r_busy;
    assign init_addr = r_cnt;

endmodule : dpram_clear_seq

// File: rtl/dual_port_ram_param.sv
// ----------------------------------------------------------------------------
// dual_port_ram_param
//  Parametrised true dual-port RAM on a single clock with registered reads,
//  per-port valid flags, selectable same-port read-during-write behaviour,
//  a hardware clear sequencer and same-address write-collision reporting.
// Ports
//  clk, rst                 clock / asynchronous active-high reset
//  clr                      re-run clear sequence (honoured when READY)
//  ena, wea, addra, dina    port A request
//  douta, valida            port A registered read data / valid
//  enb, web, addrb, dinb    port B request
//  doutb, validb            port B registered read data / valid
//  init_busy                clear sequence running, accesses ignored
//  collision                both ports wrote the same address last cycle
// ----------------------------------------------------------------------------
module dual_port_ram_param
    import dpram_pkg::*;
#(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 4,
    parameter int                 RDW_MODE = RDW_READ_FIRST,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta,
    output logic              valida,
    input  logic              enb,
    input  logic              web,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dinb,
    output logic [DATA_W-1:0] doutb,
    output logic              validb,
    output logic              init_busy,
    output logic              collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_init_busy;
    logic              w_init_we;
    logic [ADDR_W-1:0] w_init_addr;

    logic              w_acc_a;
    logic              w_acc_b;
    logic              w_usr_we_a;
    logic              w_usr_we_b;
    logic              w_same_addr;
    logic              w_collide;

    // Physical write port A is shared between the clear sequencer and user A
    logic              w_we_a;
    logic [ADDR_W-1:0] w_waddr_a;
    logic [DATA_W-1:0] w_wdata_a;
    logic              w_we_b;

    logic [DATA_W-1:0] r_douta;
    logic [DATA_W-1:0] r_doutb;
    logic              r_valida;
    logic              r_validb;
    logic              r_collision;

    dpram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .init_busy (w_init_busy),
        .init_we   (w_init_we),
        .init_addr (w_init_addr)
    );

    assign w_acc_a     = ena & ~w_init_busy;
    assign w_acc_b     = enb & ~w_init_busy;
    assign w_usr_we_a  = w_acc_a & wea;
    assign w_usr_we_b  = w_acc_b & web;
    assign w_same_addr = (addra == addrb);
    assign w_collide   = w_usr_we_a & w_usr_we_b & w_same_addr;

    // Priority: clear sequencer > port A > port B
    assign w_we_a    = w_init_we | w_usr_we_a;
    assign w_waddr_a = w_init_we ? w_init_addr : addra;
    assign w_wdata_a = w_init_we ? INIT_VAL    : dina;
    assign w_we_b    = w_usr_we_b & ~w_collide;

    // Array carries no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (w_we_a) begin
            r_mem[w_waddr_a] <= w_wdata_a;
        end
        if (w_we_b) begin
            r_mem[addrb] <= dinb;
        end
    end

    // Reads sample the array before this edge's writes, so a cross-port read
    // of a word being written always returns the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_douta     <= '0;
            r_doutb     <= '0;
            r_valida    <= 1'b0;
            r_validb    <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_valida    <= w_acc_a;
            r_validb    <= w_acc_b;
            r_collision <= w_collide;
            if (w_acc_a) begin
                if (RDW_MODE == RDW_WRITE_FIRST && wea) begin
                    r_douta <= dina;
                end else begin
                    r_douta <= r_mem[addra];
                end
            end
            if (w_acc_b) begin
                if (RDW_MODE == RDW_WRITE_FIRST && web) begin
                    r_doutb <= dinb;
                end else begin
                    r_doutb <= r_mem[addrb];
                end
            end
        end
    end

    assign douta     = r_douta;
    assign doutb     = r_doutb;
    assign valida    = r_valida;
    assign validb    = r_validb;
    assign collision = r_collision;
    assign init_busy = w_init_busy;

endmodule : dual_port_ram_param

// File: tb/tb_dual_port_ram_param.sv
// ----------------------------------------------------------------------------
// tb_dual_port_ram_param
//  Directed bench: two instances (read-first u0, write-first u1) driven by the
//  same stimulus, DATA_W=8, ADDR_W=2, INIT_VAL=8'hA5.
// ----------------------------------------------------------------------------
module tb_dual_port_ram_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
    logic [1:0] addra = '0, addrb = '0;
    logic [7:0] dina = '0, dinb = '0;

    logic [7:0] douta0, doutb0, douta1, doutb1;
    logic       valida0, validb0, valida1, validb1;
    logic       busy0, busy1, coll0, coll1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dual_port_ram_param #(.DATA_W(8), .ADDR_W(2), .RDW_MODE(0), .INIT_VAL(8'hA5)) u0 (
        .clk(clk), .rst(rst), .clr(clr),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0), .valida(valida0),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0), .validb(validb0),
        .init_busy(busy0), .collision(coll0)
    );

    dual_port_ram_param #(.DATA_W(8), .ADDR_W(2), .RDW_MODE(1), .INIT_VAL(8'hA5)) u1 (
        .clk(clk), .rst(rst), .clr(clr),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .valida(valida1),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .validb(validb1),
        .init_busy(busy1), .collision(coll1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[%0t] check %s observed=%0h expected=%0h", $time, tag, obs, exp);
    endtask

    // Advance one rising edge; leave 1 time unit for outputs to settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0; clr = 1'b0;
    endtask

    // Count cycles with init_busy high (bounded); both instances must agree
    task automatic count_busy(input string tag);
        int n;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy0) break;
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, n, 4);
        check({tag, "_busy_low_u1"}, {31'd0, busy1}, 0);
    endtask

    task automatic read_a(input logic [1:0] a, input logic [7:0] exp, input string tag);
        ena = 1'b1; wea = 1'b0; addra = a;
        tick();
        check({tag, "_douta"}, douta0, exp);
        check({tag, "_valida"}, {31'd0, valida0}, 1);
        ena = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_douta",  douta0, 0);
        check("rst_doutb",  doutb1, 0);
        check("rst_valida", {31'd0, valida0}, 0);
        check("rst_busy",   {31'd0, busy0}, 1);
        check("rst_coll",   {31'd0, coll0}, 0);

        // ---------------- 1: init after release ----------------
        rst = 1'b0;
        count_busy("t1");
        check("t1_valid_idle", {31'd0, valida0}, 0);
        for (int i = 0; i < 4; i++) read_a(2'(i), 8'hA5, $sformatf("t1_rd%0d", i));
        tick();
        check("t1_valida_drop", {31'd0, valida0}, 0);

        // ---------------- 2: A write, B read ----------------
        ena = 1'b1; wea = 1'b1; addra = 2'd1; dina = 8'h3C;
        tick();
        idle(); enb = 1'b1; addrb = 2'd1;
        tick();
        check("t2_doutb",  doutb0, 8'h3C);
        check("t2_validb", {31'd0, validb0}, 1);
        idle();
        tick();
        check("t2_validb_drop", {31'd0, validb0}, 0);
        check("t2_doutb_hold",  doutb0, 8'h3C);

        // ---------------- 3: collisions ----------------
        ena = 1'b1; wea = 1'b1; addra = 2'd2; dina = 8'h11;
        enb = 1'b1; web = 1'b1; addrb = 2'd2; dinb = 8'h22;
        tick();
        idle();
        check("t3_coll",    {31'd0, coll0}, 1);
        check("t3_coll_u1", {31'd0, coll1}, 1);
        tick();
        check("t3_coll_pulse", {31'd0, coll0}, 0);
        read_a(2'd2, 8'h11, "t3_rd2");
        ena = 1'b1; wea = 1'b1; addra = 2'd0; dina = 8'h40;
        enb = 1'b1; web = 1'b1; addrb = 2'd3; dinb = 8'h50;
        tick();
        check("t3_nocoll", {31'd0, coll0}, 0);
        ena = 1'b1; wea = 1'b0; addra = 2'd0;
        enb = 1'b1; web = 1'b0; addrb = 2'd3;
        tick();
        idle();
        check("t3_rd0", douta0, 8'h40);
        check("t3_rd3", doutb0, 8'h50);

        // ---------------- 4: read-during-write ----------------
        ena = 1'b1; wea = 1'b1; addra = 2'd1; dina = 8'h77;
        enb = 1'b1; web = 1'b0; addrb = 2'd1;
        tick();
        idle();
        check("t4_rdw0_douta", douta0, 8'h3C);
        check("t4_rdw1_douta", douta1, 8'h77);
        check("t4_rdw0_doutb", doutb0, 8'h3C);
        check("t4_rdw1_doutb", doutb1, 8'h3C);
        read_a(2'd1, 8'h77, "t4_rd1");

        // ---------------- 5: clr re-runs init ----------------
        clr = 1'b1;
        tick();
        clr = 1'b0;
        begin
            int n;
            n = 0;
            ena = 1'b1; wea = 1'b1; addra = 2'd0; dina = 8'hEE;
            enb = 1'b1; web = 1'b0; addrb = 2'd1;
            for (int k = 0; k < 20; k++) begin
                if (!busy0) break;
                n++;
                check($sformatf("t5_valida_c%0d", k), {31'd0, valida0}, 0);
                check($sformatf("t5_validb_c%0d", k), {31'd0, validb0}, 0);
                // clr is ignored while INIT runs
                clr = (k == 1);
                tick();
                clr = 1'b0;
            end
            idle();
            check("t5_busy_cycles", n, 4);
        end
        tick();
        for (int i = 0; i < 4; i++) read_a(2'(i), 8'hA5, $sformatf("t5_rd%0d", i));

        // ---------------- 6: async reset ----------------
        ena = 1'b1; wea = 1'b1; addra = 2'd2; dina = 8'h99;
        tick();
        ena = 1'b1; wea = 1'b0;
        tick();
        check("t6_pre_douta", douta0, 8'h99);
        #2 rst = 1'b1;
        #1;
        check("t6_async_douta",  douta0, 0);
        check("t6_async_valida", {31'd0, valida0}, 0);
        check("t6_async_busy",   {31'd0, busy0}, 1);
        idle();
        tick();
        rst = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("t6_midinit_busy", {31'd0, busy0}, 1);
        tick();
        rst = 1'b0;
        count_busy("t6");
        read_a(2'd2, 8'hA5, "t6_rd2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_dual_port_ram_param
